fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 165 ++++++++++++++++
 tb/tb_fetch_queue.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch queue feeding a dual-issue decode stage (S0).
//
// Each cycle there is room, the queue asks instruction memory for the pair of
// words at pc and moves pc on by two. The pair comes back one cycle later and
// is pushed as two entries, each tagged with its own address. The two oldest
// entries are shown on the S0 slots. fetch_next takes up to two of them.
//
// Parameters:
//   AW    - instruction-memory word-address width
//   IW    - instruction width
//   DEPTH - queue entries (power of two, >= 4)
//
// Ports:
//   clk, rst                   - clock; asynchronous active-high reset
//   imem_req, imem_addr        - read request for the word pair at imem_addr
//   imem_rdata                 - pair data, one cycle after imem_req
//                                ([IW-1:0] = word@addr, [2IW-1:IW] = word@addr+1)
//   fetch_next                 - S0 slots consumed this cycle
//   redirect, redirect_pc      - flush the queue and restart fetch at redirect_pc
//   s0_p0_* / s0_p1_*          - queue head / head+1 (instr, pc, valid)

module fetch_queue #(
  parameter int unsigned AW    = 8,
  parameter int unsigned IW    = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst,

  output logic            imem_req,
  output logic [AW-1:0]   imem_addr,
  input  logic [2*IW-1:0] imem_rdata,

  input  logic            fetch_next,
  input  logic            redirect,
  input  logic [AW-1:0]   redirect_pc,

  output logic [IW-1:0]   s0_p0_instr,
  output logic [IW-1:0]   s0_p1_instr,
  output logic [AW-1:0]   s0_p0_pc,
  output logic [AW-1:0]   s0_p1_pc,
  output logic            s0_p0_valid,
  output logic            s0_p1_valid
);

  localparam int unsigned PW = $clog2(DEPTH);  // pointer width
  localparam int unsigned CW = PW + 1;         // count width, holds 0..DEPTH
  localparam int unsigned OW = CW + 1;         // occupancy sum, holds DEPTH+2

  // State
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] req_pc_q, req_pc_d;  // address of the request now in flight
  logic          inflight_q, inflight_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Entry storage; contents are only visible through the valid-gated outputs,
  // so it needs no reset.
  logic [IW-1:0] instr_mem [DEPTH];
  logic [AW-1:0] pc_mem    [DEPTH];

  logic          push;
  logic [CW-1:0] pop_n;
  logic [OW-1:0] occupancy;
  logic [PW-1:0] wr_ptr_p1;
  logic [PW-1:0] rd_ptr_p1;

  // Request only when the queue can still absorb every pair already asked for
  // plus this one; this is what makes overflow impossible.
  always_comb begin
    occupancy = OW'(count_q) + (inflight_q ? OW'(2) : OW'(0));
    imem_req  = !rst && !redirect && (occupancy <= OW'(DEPTH - 2));
    imem_addr = pc_q;
  end

  always_comb begin
    push      = inflight_q && !redirect;
    wr_ptr_p1 = wr_ptr_q + PW'(1);
    rd_ptr_p1 = rd_ptr_q + PW'(1);

    // pop = min(count, 2) when S0 is consumed
    pop_n = '0;
    if (fetch_next) begin
      pop_n = (count_q >= CW'(2)) ? CW'(2) : count_q;
    end
  end

  // Next state
  always_comb begin
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = imem_req;
    rd_ptr_d   = rd_ptr_q + pop_n[PW-1:0];
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q - pop_n;

    if (imem_req) begin
      pc_d     = pc_q + AW'(2);
      req_pc_d = pc_q;
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(2);
      count_d  = count_q + CW'(2) - pop_n;
    end

    // Redirect wins over everything; a response landing this cycle is dropped.
    if (redirect) begin
      pc_d       = redirect_pc;
      inflight_d = 1'b0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= '0;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Entry writes: low word (older) first, each tagged with its own address.
  // During reset inflight_q is held low, so no write can happen.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_q]  <= imem_rdata[IW-1:0];
      pc_mem[wr_ptr_q]     <= req_pc_q;
      instr_mem[wr_ptr_p1] <= imem_rdata[2*IW-1:IW];
      pc_mem[wr_ptr_p1]    <= req_pc_q + AW'(1);
    end
  end

  // S0 slots; an empty slot drives zeros rather than stale buffer contents.
  always_comb begin
    s0_p0_valid = (count_q >= CW'(1));
    s0_p1_valid = (count_q >= CW'(2));
    s0_p0_instr = '0;
    s0_p0_pc    = '0;
    s0_p1_instr = '0;
    s0_p1_pc    = '0;
    if (s0_p0_valid) begin
      s0_p0_instr = instr_mem[rd_ptr_q];
      s0_p0_pc    = pc_mem[rd_ptr_q];
    end
    if (s0_p1_valid) begin
      s0_p1_instr = instr_mem[rd_ptr_p1];
      s0_p1_pc    = pc_mem[rd_ptr_p1];
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  localparam int unsigned AW    = 8;
  localparam int unsigned IW    = 16;
  localparam int unsigned DEPTH = 8;

  logic            clk;
  logic            rst;
  logic            imem_req;
  logic [AW-1:0]   imem_addr;
  logic [2*IW-1:0] imem_rdata;
  logic            fetch_next;
  logic            redirect;
  logic [AW-1:0]   redirect_pc;
  logic [IW-1:0]   s0_p0_instr, s0_p1_instr;
  logic [AW-1:0]   s0_p0_pc, s0_p1_pc;
  logic            s0_p0_valid, s0_p1_valid;

  int checks;
  int errors;

  fetch_queue #(
    .AW    (AW),
    .IW    (IW),
    .DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .fetch_next  (fetch_next),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .s0_p0_instr (s0_p0_instr),
    .s0_p1_instr (s0_p1_instr),
    .s0_p0_pc    (s0_p0_pc),
    .s0_p1_pc    (s0_p1_pc),
    .s0_p0_valid (s0_p0_valid),
    .s0_p1_valid (s0_p1_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: word n holds 16'h1000 + n; one-cycle read latency.
  logic [AW-1:0] last_addr;
  logic [AW-1:0] last_addr_p1;
  initial last_addr = '0;
  always @(posedge clk) if (imem_req) last_addr <= imem_addr;
  assign last_addr_p1 = last_addr + AW'(1);
  assign imem_rdata   = {16'h1000 + 16'(last_addr_p1), 16'h1000 + 16'(last_addr)};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_slots(input string tag, input logic v0, input logic [15:0] i0,
                           input logic [7:0] p0, input logic v1, input logic [15:0] i1,
                           input logic [7:0] p1);
    chk({tag, " p0_valid"}, 32'(s0_p0_valid), 32'(v0));
    chk({tag, " p0_instr"}, 32'(s0_p0_instr), 32'(i0));
    chk({tag, " p0_pc"},    32'(s0_p0_pc),    32'(p0));
    chk({tag, " p1_valid"}, 32'(s0_p1_valid), 32'(v1));
    chk({tag, " p1_instr"}, 32'(s0_p1_instr), 32'(i1));
    chk({tag, " p1_pc"},    32'(s0_p1_pc),    32'(p1));
  endtask

  task automatic chk_req(input string tag, input logic req, input logic [7:0] addr);
    chk({tag, " imem_req"},  32'(imem_req),  32'(req));
    chk({tag, " imem_addr"}, 32'(imem_addr), 32'(addr));
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    fetch_next  = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;

    // Reset state
    #1;
    chk_req("reset", 1'b0, 8'h00);
    chk_slots("reset", 1'b0, 16'h0, 8'h0, 1'b0, 16'h0, 8'h0);
    tick();
    tick();
    rst = 1'b0;
    #1;

    // Fill with fetch_next low: requests at 0,2,4,6 then stop at count 8
    chk_req("fill0", 1'b1, 8'h00);
    tick();
    chk_req("fill1", 1'b1, 8'h02);
    chk("fill1 latency p0_valid", 32'(s0_p0_valid), 32'd0);
    tick();
    chk_req("fill2", 1'b1, 8'h04);
    chk_slots("fill2", 1'b1, 16'h1000, 8'h00, 1'b1, 16'h1001, 8'h01);
    tick();
    chk_req("fill3", 1'b1, 8'h06);
    tick();
    chk("fill4 imem_req", 32'(imem_req), 32'd0);
    tick();
    chk("full imem_req", 32'(imem_req), 32'd0);
    chk_slots("full", 1'b1, 16'h1000, 8'h00, 1'b1, 16'h1001, 8'h01);
    tick();
    chk("full hold imem_req", 32'(imem_req), 32'd0);

    // Continuous consumption: one pair per cycle, in order, no gaps
    fetch_next = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk_slots($sformatf("stream%0d", i), 1'b1, 16'h1000 + 16'(2 * i), 8'(2 * i),
                1'b1, 16'h1001 + 16'(2 * i), 8'(2 * i + 1));
      tick();
    end

    // Redirect with a response in flight: response dropped, refetch at 0x40
    redirect    = 1'b1;
    redirect_pc = 8'h40;
    #1;
    chk("redirect imem_req", 32'(imem_req), 32'd0);
    tick();
    redirect = 1'b0;
    #1;
    chk_slots("post-redirect", 1'b0, 16'h0, 8'h0, 1'b0, 16'h0, 8'h0);
    chk_req("post-redirect", 1'b1, 8'h40);
    // fetch_next held high with an empty queue must not disturb state
    tick();
    chk("empty pop p0_valid", 32'(s0_p0_valid), 32'd0);
    chk("empty pop p0_instr", 32'(s0_p0_instr), 32'd0);
    chk_req("redirect+1", 1'b1, 8'h42);
    tick();
    chk_slots("redirect data", 1'b1, 16'h1040, 8'h40, 1'b1, 16'h1041, 8'h41);

    // Address wrap: request at FE tags FE/FF, next request at 00
    fetch_next  = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 8'hFE;
    tick();
    redirect = 1'b0;
    #1;
    chk_req("wrap0", 1'b1, 8'hFE);
    tick();
    chk_req("wrap1", 1'b1, 8'h00);
    tick();
    chk_slots("wrap tags", 1'b1, 16'h10FE, 8'hFE, 1'b1, 16'h10FF, 8'hFF);
    fetch_next = 1'b1;
    tick();
    chk_slots("wrap next", 1'b1, 16'h1000, 8'h00, 1'b1, 16'h1001, 8'h01);
    fetch_next = 1'b0;
    tick();

    // Asynchronous reset mid-stream: outputs clear before any clock edge
    chk("pre-rst p0_valid", 32'(s0_p0_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk_req("async rst", 1'b0, 8'h00);
    chk_slots("async rst", 1'b0, 16'h0, 8'h0, 1'b0, 16'h0, 8'h0);
    tick();
    rst = 1'b0;
    #1;
    chk_req("post-rst", 1'b1, 8'h00);
    tick();
    chk("post-rst+1 p0_valid", 32'(s0_p0_valid), 32'd0);
    tick();
    chk_slots("post-rst data", 1'b1, 16'h1000, 8'h00, 1'b1, 16'h1001, 8'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
